// File: rtl/if_fetch_pc.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_pc
// Description : Instruction-fetch front end of the five-stage MIPS pipeline.
//               Owns the program counter, selects the next PC (sequential,
//               branch/jump redirect, exception entry, eret return), drives
//               the instruction-memory address and presents the fetched word,
//               its PC and a fetch exception code to the IF/ID register.
//               A one-entry redirect buffer keeps a branch target that was
//               resolved while fetch was stalled.
//
// Ports       : clk         - clock, all state updates on the rising edge
//               reset       - synchronous, active-high reset
//               en          - 1 = advance PC, 0 = stall (hold PC)
//               br_valid    - taken branch/jump in D (one-cycle pulse)
//               br_target   - redirect target, valid with br_valid
//               exc_req     - CP0 exception/interrupt taken this cycle
//               eret_req    - eret committing this cycle
//               epc         - return address for eret
//               imem_rdata  - asynchronous instruction-memory read data
//               imem_addr   - instruction-memory address (= pc_F)
//               pc_F        - current fetch PC (registered)
//               instr_F     - fetched instruction, 0 on a fetch fault
//               excode_F    - 5'd4 (AdEL) on a fetch fault, else 0
//               pend_F      - redirect buffer holds a target
//
// Config      : IF_ADEL_EN  - when defined, alignment/range checking of the
//               fetch PC is generated; when undefined, instr_F = imem_rdata
//               and excode_F = 0 for every PC.
//
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_pc #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] EXC_ENTRY = 32'h0000_4180,
  parameter logic [31:0] IM_BASE   = 32'h0000_3000,
  parameter logic [31:0] IM_TOP    = 32'h0000_6FFC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic [31:0] imem_rdata,
  output logic [31:0] imem_addr,
  output logic [31:0] pc_F,
  output logic [31:0] instr_F,
  output logic [4:0]  excode_F,
  output logic        pend_F
);

  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic [31:0] pc;
  logic        pend_valid;
  logic [31:0] pend_target;

  logic [31:0] pc_next;
  logic        pend_valid_next;
  logic [31:0] pend_target_next;

  // Next-PC and redirect-buffer selection. Flushes (exc/eret) win over the
  // stall so that a stalled pipeline can still be redirected to the handler.
  always_comb begin
    pc_next          = pc;
    pend_valid_next  = pend_valid;
    pend_target_next = pend_target;

    if (exc_req) begin
      pc_next         = EXC_ENTRY;
      pend_valid_next = 1'b0;
    end else if (eret_req) begin
      pc_next         = epc;
      pend_valid_next = 1'b0;
    end else if (en) begin
      // Any enabled cycle consumes or discards the buffered target.
      pend_valid_next = 1'b0;
      if (br_valid) begin
        pc_next = br_target;
      end else if (pend_valid) begin
        pc_next = pend_target;
      end else begin
        pc_next = pc + 32'd4;
      end
    end else if (br_valid) begin
      // Branch resolved during a stall: remember it; newest target wins.
      pend_valid_next  = 1'b1;
      pend_target_next = br_target;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= 32'd0;
    end else begin
      pc          <= pc_next;
      pend_valid  <= pend_valid_next;
      pend_target <= pend_target_next;
    end
  end

  assign pc_F      = pc;
  assign imem_addr = pc;
  assign pend_F    = pend_valid;

`ifdef IF_ADEL_EN
  logic fetch_fault;

  // Misaligned or outside the instruction memory window (unsigned compares).
  assign fetch_fault = (pc[1:0] != 2'b00) || (pc < IM_BASE) || (pc > IM_TOP);

  assign instr_F  = fetch_fault ? 32'd0 : imem_rdata;
  assign excode_F = fetch_fault ? EXC_ADEL : 5'd0;
`else
  logic [4:0] unused_excode;

  assign unused_excode = EXC_ADEL;
  assign instr_F       = imem_rdata;
  assign excode_F      = 5'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_pc.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_pc
// Description : Self-checking bench for if_fetch_pc. Directed scenarios
//               followed by randomized control traffic, all compared against
//               a behavioural next-PC model kept in the bench.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_pc;

  localparam logic [31:0] C_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] C_EXC_ENTRY = 32'h0000_4180;
  localparam logic [31:0] C_IM_BASE   = 32'h0000_3000;
  localparam logic [31:0] C_IM_TOP    = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        br_valid;
  logic [31:0] br_target;
  logic        exc_req;
  logic        eret_req;
  logic [31:0] epc;
  logic [31:0] imem_rdata;
  logic [31:0] imem_addr;
  logic [31:0] pc_F;
  logic [31:0] instr_F;
  logic [4:0]  excode_F;
  logic        pend_F;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_pend;
  logic [31:0] m_tgt;

  always #5 clk = ~clk;

  // Instruction memory: arbitrary deterministic word per address.
  assign imem_rdata = (imem_addr * 32'h9E37_79B1) ^ 32'h1234_5678;

  if_fetch_pc dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .br_valid   (br_valid),
    .br_target  (br_target),
    .exc_req    (exc_req),
    .eret_req   (eret_req),
    .epc        (epc),
    .imem_rdata (imem_rdata),
    .imem_addr  (imem_addr),
    .pc_F       (pc_F),
    .instr_F    (instr_F),
    .excode_F   (excode_F),
    .pend_F     (pend_F)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic logic is_fault(input logic [31:0] a);
`ifdef IF_ADEL_EN
    return (a % 4 != 0) || (a < C_IM_BASE) || (a > C_IM_TOP);
`else
    return 1'b0;
`endif
  endfunction

  task automatic compare_all();
    check_eq("pc_F", pc_F, m_pc);
    check_eq("imem_addr", imem_addr, m_pc);
    check_eq("pend_F", {31'd0, pend_F}, {31'd0, m_pend});
    check_eq("instr_F", instr_F, is_fault(m_pc) ? 32'd0 : mem_word(m_pc));
    check_eq("excode_F", {27'd0, excode_F}, is_fault(m_pc) ? 32'd4 : 32'd0);
  endtask

  // Apply one cycle of inputs, advance the model by the priority rules,
  // then compare just after the edge.
  task automatic step(input logic rs, input logic e, input logic b, input logic [31:0] t,
                      input logic x, input logic r, input logic [31:0] ep);
    reset = rs; en = e; br_valid = b; br_target = t;
    exc_req = x; eret_req = r; epc = ep;
    @(posedge clk);
    if (rs) begin
      m_pc = C_RESET_PC; m_pend = 1'b0; m_tgt = 32'd0;
    end else if (x) begin
      m_pc = C_EXC_ENTRY; m_pend = 1'b0;
    end else if (r) begin
      m_pc = ep; m_pend = 1'b0;
    end else if (e) begin
      if (b)           m_pc = t;
      else if (m_pend) m_pc = m_tgt;
      else             m_pc = m_pc + 32'd4;
      m_pend = 1'b0;
    end else if (b) begin
      m_pend = 1'b1; m_tgt = t;
    end
    #1;
    compare_all();
  endtask

  task automatic adv();
    step(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  initial begin
    m_pc = 32'd0; m_pend = 1'b0; m_tgt = 32'd0;
    reset = 1'b1; en = 1'b0; br_valid = 1'b0; br_target = 32'd0;
    exc_req = 1'b0; eret_req = 1'b0; epc = 32'd0;

    // Reset
    step(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    check_eq("reset_pc", pc_F, 32'h3000);

    // Sequential fetch
    adv(); check_eq("seq_3004", pc_F, 32'h3004);
    adv(); check_eq("seq_3008", pc_F, 32'h3008);
    adv(); check_eq("seq_300c", pc_F, 32'h300C);
    adv(); check_eq("seq_3010", pc_F, 32'h3010);

    // Direct branch
    step(1'b0, 1'b1, 1'b1, 32'h3100, 1'b0, 1'b0, 32'd0);
    check_eq("br_direct", pc_F, 32'h3100);
    check_eq("br_direct_nopend", {31'd0, pend_F}, 32'd0);

    // Buffered branch across a stall at 0x3020
    step(1'b0, 1'b1, 1'b1, 32'h3020, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h3200, 1'b0, 1'b0, 32'd0);
    check_eq("stall_hold", pc_F, 32'h3020);
    check_eq("stall_pend", {31'd0, pend_F}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0);
    adv();
    check_eq("pend_release", pc_F, 32'h3200);
    check_eq("pend_cleared", {31'd0, pend_F}, 32'd0);

    // Exception while pending, then eret
    step(1'b0, 1'b1, 1'b1, 32'h3020, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h3200, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0);
    check_eq("exc_entry", pc_F, 32'h4180);
    check_eq("exc_clr_pend", {31'd0, pend_F}, 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'h3024);
    check_eq("eret_pc", pc_F, 32'h3024);

    // Fetch-fault boundaries (model decides fault vs. no fault per build)
    step(1'b0, 1'b1, 1'b1, 32'h3002, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'h7000, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'h2FFC, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'h6FFC, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b1, 1'b1, 32'h3000, 1'b0, 1'b0, 32'd0);
    // Wrap-around
    step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'd0);
    adv();
    check_eq("wrap", pc_F, 32'h0000_0000);

    // Simultaneous events while stalled
    step(1'b0, 1'b0, 1'b1, 32'h3300, 1'b1, 1'b1, 32'h3500);
    check_eq("simul_exc", pc_F, 32'h4180);
    check_eq("simul_no_buf", {31'd0, pend_F}, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h3300, 1'b0, 1'b0, 32'd0);
    step(1'b1, 1'b0, 1'b1, 32'h3400, 1'b1, 1'b1, 32'h3500);
    check_eq("simul_reset", pc_F, 32'h3000);
    check_eq("reset_clr_pend", {31'd0, pend_F}, 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic        r_rs, r_e, r_b, r_x, r_r;
      logic [31:0] r_t, r_ep;
      r_rs = ($urandom_range(0, 99) < 2);
      r_e  = ($urandom_range(0, 99) < 65);
      r_b  = ($urandom_range(0, 99) < 25);
      r_x  = ($urandom_range(0, 99) < 4);
      r_r  = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 9) == 0) r_t = $urandom;
      else r_t = C_IM_BASE + ($urandom_range(0, 32'h3FFF) & 32'hFFFF_FFFC);
      if ($urandom_range(0, 9) == 0) r_ep = $urandom;
      else r_ep = C_IM_BASE + ($urandom_range(0, 32'h3FFF) & 32'hFFFF_FFFC);
      step(r_rs, r_e, r_b, r_t, r_x, r_r, r_ep);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
